// File: rtl/sme_pkg.sv
// Shared types and constants for the string-matching engine host and engine.
package sme_pkg;

  localparam int unsigned STR_DEPTH = 32;
  localparam int unsigned PAT_DEPTH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSendStr,
    StSendPat,
    StWait,
    StDone
  } sme_state_e;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_REQ = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] CARET  = 8'h5E;
  localparam logic [7:0] SPACE  = 8'h20;

endpackage

// File: rtl/sme_char_buf.sv
// Append-only character buffer with length tracking and a sticky overflow flag.
module sme_char_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = $clog2(DEPTH + 1),
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic [LEN_W-1:0] len,
  output logic             ovf
);

  logic [7:0] mem [DEPTH];
  logic       full;

  assign full    = (len == LEN_W'(DEPTH));
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (wr_en) begin
      if (full) begin
        ovf <= 1'b1;
      end else begin
        len <= len + 1'b1;
      end
    end
  end

  // Contents are don't-care until written, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en && !clr && !full) begin
      mem[len[IDX_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/sme_host.sv
// Initiator for the string-matching engine: buffers a string and pattern, streams them
// out back to back, then waits (with timeout) for the engine result.
module sme_host #(
  parameter int unsigned STR_DEPTH = sme_pkg::STR_DEPTH,
  parameter int unsigned PAT_DEPTH = sme_pkg::PAT_DEPTH,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       clr,
  input  logic       start,
  input  logic       reuse_str,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] res_err,
  output logic       ovf
);

  import sme_pkg::*;

  localparam int unsigned STR_LW = $clog2(STR_DEPTH + 1);
  localparam int unsigned PAT_LW = $clog2(PAT_DEPTH + 1);
  localparam int unsigned STR_IW = $clog2(STR_DEPTH);
  localparam int unsigned PAT_IW = $clog2(PAT_DEPTH);
  localparam int unsigned IDX_W  = (STR_LW > PAT_LW) ? STR_LW : PAT_LW;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT);

  sme_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [TMO_W-1:0]  tmo;
  logic              str_sent;

  logic              idle;
  logic [STR_LW-1:0] str_len;
  logic [PAT_LW-1:0] pat_len;
  logic [STR_IW-1:0] str_rd_idx;
  logic [PAT_IW-1:0] pat_rd_idx;
  logic [7:0]        str_rd_data;
  logic [7:0]        pat_rd_data;
  logic              str_ovf;
  logic              pat_ovf;

  assign idle = (state == StIdle);
  assign ovf  = str_ovf | pat_ovf;

  // Outside the active send state the read index sits at 0 so the first char of the next
  // stream is already presented when the FSM moves into it.
  always_comb begin
    str_rd_idx = '0;
    pat_rd_idx = '0;
    if (state == StSendStr) str_rd_idx = idx[STR_IW-1:0];
    if (state == StSendPat) pat_rd_idx = idx[PAT_IW-1:0];
  end

  sme_char_buf #(
    .DEPTH (STR_DEPTH)
  ) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr && idle),
    .wr_en   (wr_en && idle && !wr_sel),
    .wr_data (wr_data),
    .rd_idx  (str_rd_idx),
    .rd_data (str_rd_data),
    .len     (str_len),
    .ovf     (str_ovf)
  );

  sme_char_buf #(
    .DEPTH (PAT_DEPTH)
  ) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr && idle),
    .wr_en   (wr_en && idle && wr_sel),
    .wr_data (wr_data),
    .rd_idx  (pat_rd_idx),
    .rd_data (pat_rd_data),
    .len     (pat_len),
    .ovf     (pat_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      idx       <= '0;
      tmo       <= '0;
      str_sent  <= 1'b0;
      busy      <= 1'b0;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      res_err   <= ERR_OK;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (clr) begin
            str_sent <= 1'b0;
          end else if (start) begin
            if (!reuse_str && str_len != '0 && pat_len != '0) begin
              state    <= StSendStr;
              busy     <= 1'b1;
              chardata <= str_rd_data;
              isstring <= 1'b1;
              idx      <= IDX_W'(1);
              str_sent <= 1'b1;
            end else if (reuse_str && str_sent && pat_len != '0) begin
              state     <= StSendPat;
              busy      <= 1'b1;
              chardata  <= pat_rd_data;
              ispattern <= 1'b1;
              idx       <= IDX_W'(1);
            end else begin
              state     <= StDone;
              res_valid <= 1'b1;
              res_err   <= ERR_REQ;
              res_match <= 1'b0;
              res_index <= '0;
            end
          end
        end
        StSendStr: begin
          // The engine reads a gap as end-of-pattern, so the handover is seamless.
          if (idx == IDX_W'(str_len)) begin
            state     <= StSendPat;
            isstring  <= 1'b0;
            ispattern <= 1'b1;
            chardata  <= pat_rd_data;
            idx       <= IDX_W'(1);
          end else begin
            chardata <= str_rd_data;
            idx      <= idx + 1'b1;
          end
        end
        StSendPat: begin
          if (idx == IDX_W'(pat_len)) begin
            state     <= StWait;
            ispattern <= 1'b0;
            chardata  <= '0;
            tmo       <= '0;
          end else begin
            chardata <= pat_rd_data;
            idx      <= idx + 1'b1;
          end
        end
        StWait: begin
          if (valid) begin
            state     <= StDone;
            busy      <= 1'b0;
            res_valid <= 1'b1;
            res_match <= match;
            res_index <= match_index;
            res_err   <= ERR_OK;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            state     <= StDone;
            busy      <= 1'b0;
            res_valid <= 1'b1;
            res_match <= 1'b0;
            res_index <= '0;
            res_err   <= ERR_TMO;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sme_host.sv
// Randomized self-checking bench for sme_host with a queue-based reference model
// and a behavioural engine responder.
module tb_sme_host;

  localparam int TMO = 64;
  localparam int SD  = 32;
  localparam int PD  = 8;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic       wr_sel;
  logic [7:0] wr_data;
  logic       clr;
  logic       start;
  logic       reuse_str;
  logic       busy;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;
  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic [1:0] res_err;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_str[$];
  logic [7:0] m_pat[$];
  bit         m_sent;
  bit         m_ovf;

  // Responder configuration
  bit         resp_en;
  int         resp_delay;
  bit         resp_match;
  logic [4:0] resp_index;
  int         resp_since;

  sme_host #(
    .STR_DEPTH (SD),
    .PAT_DEPTH (PD),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .clr         (clr),
    .start       (start),
    .reuse_str   (reuse_str),
    .busy        (busy),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .res_valid   (res_valid),
    .res_match   (res_match),
    .res_index   (res_index),
    .res_err     (res_err),
    .ovf         (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine stand-in: raises valid resp_delay cycles after the last pattern char.
  // match/match_index carry junk whenever valid is low.
  initial begin
    valid       = 1'b0;
    match       = 1'b0;
    match_index = '0;
    resp_since  = -1;
    forever begin
      @(posedge clk);
      #1;
      valid       = 1'b0;
      match       = 1'($urandom);
      match_index = 5'($urandom);
      if (ispattern === 1'b1) begin
        resp_since = 0;
      end else if (resp_since >= 0) begin
        resp_since++;
        if (resp_en && resp_since == resp_delay) begin
          valid       = 1'b1;
          match       = resp_match;
          match_index = resp_index;
          resp_since  = -1;
        end else if (resp_since > 200) begin
          resp_since = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_str.delete();
    m_pat.delete();
    m_sent = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic write_char(input bit sel, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = ch;
    tick();
    wr_en = 1'b0;
    if (sel) begin
      if (m_pat.size() == PD) m_ovf = 1'b1;
      else m_pat.push_back(ch);
    end else begin
      if (m_str.size() == SD) m_ovf = 1'b1;
      else m_str.push_back(ch);
    end
  endtask

  task automatic load(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) write_char(sel, s[i]);
  endtask

  task automatic load_rand(input bit sel, input int n);
    for (int i = 0; i < n; i++) write_char(sel, 8'($urandom_range(32, 126)));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
  endtask

  task automatic check_ovf(input string name);
    checks++;
    if (ovf !== m_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", name, ovf, m_ovf);
    end
  endtask

  // Launch one transaction and check every cycle up to and after res_valid against the
  // model's expected timeline.
  task automatic run_txn(input string name, input bit reuse, input bit en, input int d,
                         input bit mt, input logic [4:0] mi);
    bit         legal;
    bit         tmo_exp;
    bit         bad;
    bit         s_exp;
    bit         p_exp;
    bit         b_exp;
    int         sl;
    int         pl;
    int         rv_exp;
    int         rv_obs;
    logic [1:0] err_exp;
    logic [7:0] c_exp;
    string      why;

    legal   = reuse ? (m_sent && m_pat.size() > 0) : (m_str.size() > 0 && m_pat.size() > 0);
    sl      = (legal && !reuse) ? m_str.size() : 0;
    pl      = legal ? m_pat.size() : 0;
    tmo_exp = legal && !(en && d >= 1 && d <= TMO);
    if (!legal) begin
      rv_exp  = 1;
      err_exp = 2'd1;
    end else if (tmo_exp) begin
      rv_exp  = sl + pl + TMO + 1;
      err_exp = 2'd2;
    end else begin
      rv_exp  = sl + pl + d + 1;
      err_exp = 2'd0;
    end

    resp_en    = en;
    resp_delay = d;
    resp_match = mt;
    resp_index = mi;

    start     = 1'b1;
    reuse_str = reuse;
    tick();
    start     = 1'b0;
    reuse_str = 1'b0;

    bad    = 1'b0;
    rv_obs = -1;
    why    = "";
    for (int n = 1; n <= rv_exp + 4; n++) begin
      s_exp = (n <= sl);
      p_exp = (n > sl) && (n <= sl + pl);
      c_exp = s_exp ? m_str[n-1] : (p_exp ? m_pat[n-sl-1] : 8'h00);
      b_exp = legal && (n < rv_exp);
      if (!bad && ({isstring, ispattern, chardata, busy} !== {s_exp, p_exp, c_exp, b_exp}))
      begin
        bad = 1'b1;
        why = $sformatf("cycle %0d isstring/ispattern/chardata/busy got %b/%b/%h/%b want %b/%b/%h/%b",
                        n, isstring, ispattern, chardata, busy, s_exp, p_exp, c_exp, b_exp);
      end
      if (res_valid === 1'b1) begin
        rv_obs = n;
        break;
      end
      tick();
    end

    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s stream: %s", name, why);
    end
    checks++;
    if (rv_obs != rv_exp) begin
      errors++;
      $display("FAIL %s res_valid cycle: got %0d want %0d", name, rv_obs, rv_exp);
    end
    if (rv_obs == rv_exp) begin
      checks++;
      if (res_err !== err_exp) begin
        errors++;
        $display("FAIL %s res_err: got %0d want %0d", name, res_err, err_exp);
      end
      if (legal) begin
        checks++;
        if ({res_match, res_index} !== (tmo_exp ? 6'd0 : {mt, mi})) begin
          errors++;
          $display("FAIL %s result: got match=%b index=%0d want match=%b index=%0d", name,
                   res_match, res_index, tmo_exp ? 1'b0 : mt, tmo_exp ? 5'd0 : mi);
        end
      end
      tick();
      checks++;
      if ({res_valid, busy, res_err} !== {1'b0, 1'b0, err_exp}) begin
        errors++;
        $display("FAIL %s after: got res_valid=%b busy=%b res_err=%0d want 0/0/%0d", name,
                 res_valid, busy, res_err, err_exp);
      end
    end
    if (legal && !reuse) m_sent = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_sel    = 1'b0;
    wr_data   = '0;
    clr       = 1'b0;
    start     = 1'b0;
    reuse_str = 1'b0;
    resp_en   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    checks++;
    if ({busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err, ovf}
        !== 21'd0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b char=%h is=%b ip=%b rv=%b rm=%b ri=%0d re=%0d ovf=%b want all 0",
               busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err, ovf);
    end
  endtask

  task automatic test_basic();
    do_clr();
    load(1'b0, "abcd");
    load(1'b1, "cd");
    run_txn("basic", 1'b0, 1'b1, 3, 1'b1, 5'd2);
    run_txn("reuse", 1'b1, 1'b1, 3, 1'b0, 5'd7);
  endtask

  task automatic test_illegal();
    do_clr();
    load(1'b0, "xy");
    run_txn("no_pattern", 1'b0, 1'b1, 2, 1'b1, 5'd1);
    load(1'b1, "y");
    run_txn("fresh_ok", 1'b0, 1'b1, 2, 1'b1, 5'd1);
    do_clr();
    load(1'b0, "xy");
    load(1'b1, "y");
    run_txn("reuse_after_clr", 1'b1, 1'b1, 2, 1'b1, 5'd1);
  endtask

  task automatic test_overflow();
    do_clr();
    load_rand(1'b0, SD);
    check_ovf("str_full_no_ovf");
    load_rand(1'b0, 1);
    check_ovf("str_33rd_write");
    load_rand(1'b1, PD + 1);
    check_ovf("pat_overflow");
    run_txn("ovf_full", 1'b0, 1'b1, int'($urandom_range(1, 10)), 1'b1, 5'($urandom));
    do_clr();
    check_ovf("clr_clears_ovf");
  endtask

  task automatic test_timeout();
    do_clr();
    load_rand(1'b0, 4);
    load_rand(1'b1, 3);
    run_txn("timeout", 1'b0, 1'b0, 0, 1'b0, 5'd0);
    run_txn("valid_on_tmo_cycle", 1'b1, 1'b1, TMO, 1'b1, 5'($urandom));
    run_txn("valid_first_wait", 1'b1, 1'b1, 1, 1'b1, 5'($urandom));
  endtask

  task automatic test_mid_reset();
    bit seen;
    do_clr();
    load(1'b0, "hello");
    load(1'b1, "lo");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (isstring !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset pre: got isstring=%b want 1", isstring);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    checks++;
    if ({isstring, ispattern, busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset post: got is/ip/busy=%b%b%b want 000", isstring, ispattern, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (res_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset no_result: got res_valid=1 want 0");
    end
    run_txn("post_reset_empty", 1'b0, 1'b1, 2, 1'b0, 5'd0);
    load(1'b0, "world");
    load(1'b1, "or");
    run_txn("post_reset_fresh", 1'b0, 1'b1, 4, 1'b1, 5'd1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_clr();
      load_rand(1'b0, int'($urandom_range(0, SD + 1)));
      load_rand(1'b1, int'($urandom_range(0, PD + 1)));
      check_ovf("rand_ovf");
      run_txn("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 5) != 0,
              int'($urandom_range(1, 70)), 1'($urandom), 5'($urandom));
      run_txn("rand_reuse", 1'b1, $urandom_range(0, 5) != 0,
              int'($urandom_range(1, 70)), 1'($urandom), 5'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_overflow();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
